// File: rtl/field_store_if.sv
// field_store_if: bundle between field_store and its clients (iterator, editor, display).
//   master: iterator/editor/display side, drives requests and addresses, receives read data
//   slave : field_store side
//   i_cur_read_field: 0 selects field A as the read field, 1 selects field B
interface field_store_if #(
  parameter int FIELD_W = 5,
  parameter int FIELD_H = 3
);
  localparam int X_ADR_SIZE = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE = $clog2(FIELD_H);
  logic                  i_cur_read_field;
  logic                  i_is_simulating;
  logic [X_ADR_SIZE-1:0] i_rd_x;
  logic [Y_ADR_SIZE-1:0] i_rd_y;
  logic                  o_next_cell_state;
  logic [7:0]            o_next_nbrs;
  logic                  i_wr_en;
  logic [X_ADR_SIZE-1:0] i_wr_x;
  logic [Y_ADR_SIZE-1:0] i_wr_y;
  logic                  i_wr_state;
  logic                  i_edit_en;
  logic [X_ADR_SIZE-1:0] i_edit_x;
  logic [Y_ADR_SIZE-1:0] i_edit_y;
  logic                  i_clear;
  logic [X_ADR_SIZE-1:0] i_disp_x;
  logic [Y_ADR_SIZE-1:0] i_disp_y;
  logic                  o_disp_state;
  modport master (
    output i_cur_read_field, i_is_simulating, i_rd_x, i_rd_y,
    output i_wr_en, i_wr_x, i_wr_y, i_wr_state,
    output i_edit_en, i_edit_x, i_edit_y, i_clear, i_disp_x, i_disp_y,
    input  o_next_cell_state, o_next_nbrs, o_disp_state
  );
  modport slave (
    input  i_cur_read_field, i_is_simulating, i_rd_x, i_rd_y,
    input  i_wr_en, i_wr_x, i_wr_y, i_wr_state,
    input  i_edit_en, i_edit_x, i_edit_y, i_clear, i_disp_x, i_disp_y,
    output o_next_cell_state, o_next_nbrs, o_disp_state
  );
endinterface

// File: rtl/field_store.sv
// field_store: double-buffered Game of Life cell storage.
//   clk, rst_n (async, active-low) plain ports; everything else on bus (field_store_if.slave).
//   Iterator reads cell + 8 neighbours of the read field, writes the opposite field;
//   user edits toggle read-field cells when idle; display reads the read field.
//   Neighbour bits: b0..b2 = row above (dx -1,0,+1), b3/b4 = left/right, b5..b7 = row below.
//   Optional macro FIELD_STORE_TORUS_EN: neighbours wrap around the edges (else read as 0).
module field_store #(
  parameter int FIELD_W = 5,
  parameter int FIELD_H = 3
) (
  input logic clk,
  input logic rst_n,
  field_store_if.slave bus
);
  localparam int X_ADR_SIZE = $clog2(FIELD_W);
  localparam int Y_ADR_SIZE = $clog2(FIELD_H);
  logic [FIELD_H-1:0][FIELD_W-1:0] fa, fb;
  logic [7:0] nbrs_d;
  logic rd_ok, wr_ok, edit_ok, disp_ok;
  function automatic logic cell_at(input logic sel, input int x, input int y);
    int xx, yy;
`ifdef FIELD_STORE_TORUS_EN
    xx = x < 0 ? x + FIELD_W : x >= FIELD_W ? x - FIELD_W : x;
    yy = y < 0 ? y + FIELD_H : y >= FIELD_H ? y - FIELD_H : y;
`else
    if (x < 0 || x >= FIELD_W || y < 0 || y >= FIELD_H) return 1'b0;
    xx = x;
    yy = y;
`endif
    return sel ? fb[Y_ADR_SIZE'(yy)][X_ADR_SIZE'(xx)] : fa[Y_ADR_SIZE'(yy)][X_ADR_SIZE'(xx)];
  endfunction
  always_comb begin
    rd_ok   = int'(bus.i_rd_x) < FIELD_W && int'(bus.i_rd_y) < FIELD_H;
    wr_ok   = int'(bus.i_wr_x) < FIELD_W && int'(bus.i_wr_y) < FIELD_H;
    edit_ok = int'(bus.i_edit_x) < FIELD_W && int'(bus.i_edit_y) < FIELD_H;
    disp_ok = int'(bus.i_disp_x) < FIELD_W && int'(bus.i_disp_y) < FIELD_H;
    nbrs_d  = '0;
    // k walks the 3x3 window row-major, skipping the centre (window index 4)
    for (int k = 0; k < 8; k++)
      nbrs_d[k] = rd_ok && cell_at(bus.i_cur_read_field,
                                   int'(bus.i_rd_x) + (k < 4 ? k : k + 1) % 3 - 1,
                                   int'(bus.i_rd_y) + (k < 4 ? k : k + 1) / 3 - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa                    <= '0;
      fb                    <= '0;
      bus.o_next_cell_state <= 1'b0;
      bus.o_next_nbrs       <= '0;
      bus.o_disp_state      <= 1'b0;
    end else begin
      bus.o_next_cell_state <= rd_ok && cell_at(bus.i_cur_read_field, int'(bus.i_rd_x), int'(bus.i_rd_y));
      bus.o_next_nbrs       <= nbrs_d;
      bus.o_disp_state      <= disp_ok && cell_at(bus.i_cur_read_field, int'(bus.i_disp_x), int'(bus.i_disp_y));
      if (bus.i_clear) begin
        fa <= '0;
        fb <= '0;
      end else begin
        // write and edit always target different fields, so both may fire together
        if (bus.i_wr_en && wr_ok) begin
          if (bus.i_cur_read_field) fa[bus.i_wr_y][bus.i_wr_x] <= bus.i_wr_state;
          else fb[bus.i_wr_y][bus.i_wr_x] <= bus.i_wr_state;
        end
        if (bus.i_edit_en && !bus.i_is_simulating && edit_ok) begin
          if (bus.i_cur_read_field) fb[bus.i_edit_y][bus.i_edit_x] <= ~fb[bus.i_edit_y][bus.i_edit_x];
          else fa[bus.i_edit_y][bus.i_edit_x] <= ~fa[bus.i_edit_y][bus.i_edit_x];
        end
      end
    end
  end
endmodule

// File: tb/tb_field_store.sv
// tb_field_store: self-checking bench for field_store (reference model + directed literals).
module tb_field_store;
  localparam int W = 5;
  localparam int H = 3;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
`ifdef FIELD_STORE_TORUS_EN
  localparam bit TORUS = 1'b1;
`else
  localparam bit TORUS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  field_store_if #(.FIELD_W(W), .FIELD_H(H)) bus ();
  field_store #(.FIELD_W(W), .FIELD_H(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int passed = 0;
  int total = 0;
  bit chk_en = 1'b0;
  bit m[2][H][W];
  logic e_state = 1'b0;
  logic e_disp = 1'b0;
  logic [7:0] e_nbrs = 8'h00;
  task automatic check(string nm, logic [7:0] got, logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, want %h at %0t", nm, got, exp, $time);
  endtask
  function automatic bit mcell(bit s, int x, int y);
    if (TORUS) begin
      x = (x + W) % W;
      y = (y + H) % H;
    end else if (x < 0 || x >= W || y < 0 || y >= H) return 1'b0;
    return m[s][y][x];
  endfunction
  function automatic bit mread(bit s, int x, int y);
    if (x >= W || y >= H) return 1'b0;
    return m[s][y][x];
  endfunction
  function automatic logic [7:0] mnbrs(bit s, int x, int y);
    logic [7:0] n = 8'h00;
    int b = 0;
    if (x >= W || y >= H) return 8'h00;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0) begin
          n[b] = mcell(s, x + dx, y + dy);
          b++;
        end
    return n;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_state <= 1'b0;
      e_nbrs  <= 8'h00;
      e_disp  <= 1'b0;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          m[0][y][x] <= 1'b0;
          m[1][y][x] <= 1'b0;
        end
    end else begin
      e_state <= mread(bus.i_cur_read_field, int'(bus.i_rd_x), int'(bus.i_rd_y));
      e_nbrs  <= mnbrs(bus.i_cur_read_field, int'(bus.i_rd_x), int'(bus.i_rd_y));
      e_disp  <= mread(bus.i_cur_read_field, int'(bus.i_disp_x), int'(bus.i_disp_y));
      if (bus.i_clear) begin
        for (int y = 0; y < H; y++)
          for (int x = 0; x < W; x++) begin
            m[0][y][x] <= 1'b0;
            m[1][y][x] <= 1'b0;
          end
      end else begin
        if (bus.i_wr_en && int'(bus.i_wr_x) < W && int'(bus.i_wr_y) < H)
          m[!bus.i_cur_read_field][int'(bus.i_wr_y)][int'(bus.i_wr_x)] <= bus.i_wr_state;
        if (bus.i_edit_en && !bus.i_is_simulating && int'(bus.i_edit_x) < W && int'(bus.i_edit_y) < H)
          m[bus.i_cur_read_field][int'(bus.i_edit_y)][int'(bus.i_edit_x)] <=
            !m[bus.i_cur_read_field][int'(bus.i_edit_y)][int'(bus.i_edit_x)];
      end
    end
  end
  always @(negedge clk)
    if (chk_en) begin
      check("model.state", {7'd0, bus.o_next_cell_state}, {7'd0, e_state});
      check("model.nbrs", bus.o_next_nbrs, e_nbrs);
      check("model.disp", {7'd0, bus.o_disp_state}, {7'd0, e_disp});
    end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic rd(int x, int y);
    bus.i_rd_x = XW'(x);
    bus.i_rd_y = YW'(y);
    bus.i_disp_x = XW'(x);
    bus.i_disp_y = YW'(y);
    step();
  endtask
  task automatic edit(int x, int y);
    bus.i_edit_x = XW'(x);
    bus.i_edit_y = YW'(y);
    bus.i_edit_en = 1'b1;
    step();
    bus.i_edit_en = 1'b0;
  endtask
  task automatic lit(string nm, logic st, logic [7:0] nb, logic dp);
    check({nm, ".state"}, {7'd0, bus.o_next_cell_state}, {7'd0, st});
    check({nm, ".nbrs"}, bus.o_next_nbrs, nb);
    check({nm, ".disp"}, {7'd0, bus.o_disp_state}, {7'd0, dp});
  endtask
  initial begin
    bus.i_cur_read_field = 1'b0;
    bus.i_is_simulating = 1'b0;
    bus.i_rd_x = '0;
    bus.i_rd_y = '0;
    bus.i_wr_en = 1'b0;
    bus.i_wr_x = '0;
    bus.i_wr_y = '0;
    bus.i_wr_state = 1'b0;
    bus.i_edit_en = 1'b0;
    bus.i_edit_x = '0;
    bus.i_edit_y = '0;
    bus.i_clear = 1'b0;
    bus.i_disp_x = '0;
    bus.i_disp_y = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk_en = 1'b1;
    rd(0, 0); lit("empty00", 1'b0, 8'h00, 1'b0);
    rd(4, 2); lit("empty42", 1'b0, 8'h00, 1'b0);
    edit(1, 1);
    rd(1, 1); lit("edit11", 1'b1, 8'h00, 1'b1);
    rd(0, 0); lit("nb00", 1'b0, 8'h80, 1'b0);
    rd(2, 2); lit("nb22", 1'b0, 8'h01, 1'b0);
    edit(0, 1);
    rd(4, 1); lit("edge41", 1'b0, TORUS ? 8'h10 : 8'h00, 1'b0);
    bus.i_wr_en = 1'b1;
    bus.i_wr_state = 1'b1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        bus.i_wr_x = XW'(x);
        bus.i_wr_y = YW'(y);
        step();
      end
    bus.i_wr_en = 1'b0;
    rd(1, 1); lit("A11", 1'b1, 8'h08, 1'b1);
    rd(2, 2); lit("A22", 1'b0, 8'h01, 1'b0);
    bus.i_cur_read_field = 1'b1;
    rd(2, 1); lit("B21", 1'b1, 8'hFF, 1'b1);
    rd(0, 0); lit("B00", 1'b1, TORUS ? 8'hFF : 8'hD0, 1'b1);
    rd(4, 2); lit("B42", 1'b1, TORUS ? 8'hFF : 8'h0B, 1'b1);
    rd(5, 1); lit("Boor", 1'b0, 8'h00, 1'b0);
    bus.i_rd_x = XW'(3);
    bus.i_rd_y = YW'(0);
    bus.i_disp_x = XW'(3);
    bus.i_disp_y = YW'(0);
    edit(3, 0); lit("rde30", 1'b1, TORUS ? 8'hFF : 8'hF8, 1'b1);
    rd(3, 0); lit("post30", 1'b0, TORUS ? 8'hFF : 8'hF8, 1'b0);
    rd(3, 1); lit("B31", 1'b1, 8'hFD, 1'b1);
    bus.i_cur_read_field = 1'b0;
    bus.i_is_simulating = 1'b1;
    edit(2, 1);
    rd(2, 1); lit("simblk", 1'b0, 8'h08, 1'b0);
    bus.i_is_simulating = 1'b0;
    edit(2, 1);
    rd(2, 1); lit("simfree", 1'b1, 8'h08, 1'b1);
    rd(1, 1); lit("A11b", 1'b1, 8'h18, 1'b1);
    bus.i_clear = 1'b1;
    bus.i_wr_en = 1'b1;
    bus.i_wr_x = XW'(3);
    bus.i_wr_y = YW'(2);
    bus.i_edit_x = XW'(3);
    bus.i_edit_y = YW'(2);
    bus.i_edit_en = 1'b1;
    step();
    bus.i_clear = 1'b0;
    bus.i_wr_en = 1'b0;
    bus.i_edit_en = 1'b0;
    for (int s = 0; s < 2; s++) begin
      bus.i_cur_read_field = s[0];
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          rd(x, y);
          lit("clr", 1'b0, 8'h00, 1'b0);
        end
    end
    bus.i_cur_read_field = 1'b0;
    edit(6, 0);
    edit(2, 1);
    rd(2, 1); lit("pre_rst", 1'b1, 8'h00, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    lit("async_rst", 1'b0, 8'h00, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    rd(2, 1); lit("post_rst", 1'b0, 8'h00, 1'b0);
    rd(0, 0); lit("post_rst00", 1'b0, 8'h00, 1'b0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/field_store.md
Name: field_store

Overview:
- Double-buffered cell storage for the Game of Life core. It is the responder to next_field_iter.
- Serves the registered cell state and 8-neighbour vector at the iterator's requested (next_x, next_y), taken from the current read field.
- Accepts new cell states from the iterator into the opposite (write) field.
- Also provides a user edit port (toggle a cell) and a display read port for the video scanner.

Parameters:
- FIELD_W, 5, field width in cells (>=3)
- FIELD_H, 3, field height in cells (>=3)
- X_ADR_SIZE, $clog2(FIELD_W), x address width (derived, not overridden)
- Y_ADR_SIZE, $clog2(FIELD_H), y address width (derived, not overridden)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- i_cur_read_field  in  field_t  field currently read by iterator; write field is ~i_cur_read_field
- i_is_simulating  in  1  iterator busy; blocks edits
- i_rd_x  in  X_ADR_SIZE  requested cell x (iterator o_next_x)
- i_rd_y  in  Y_ADR_SIZE  requested cell y (iterator o_next_y)
- o_next_cell_state  out  1  state of requested cell, registered
- o_next_nbrs  out  8  neighbour states of requested cell, registered
- i_wr_en  in  1  write strobe (iterator o_is_simulating)
- i_wr_x  in  X_ADR_SIZE  write x (iterator o_cur_x)
- i_wr_y  in  Y_ADR_SIZE  write y (iterator o_cur_y)
- i_wr_state  in  1  new cell state (iterator o_new_cur_cell_state)
- i_edit_en  in  1  toggle one cell of the read field
- i_edit_x  in  X_ADR_SIZE  edit x
- i_edit_y  in  Y_ADR_SIZE  edit y
- i_clear  in  1  zero both fields
- i_disp_x  in  X_ADR_SIZE  display read x
- i_disp_y  in  Y_ADR_SIZE  display read y
- o_disp_state  out  1  read-field cell at display address, registered

Behaviour:
- Storage: two FIELD_H x FIELD_W bit arrays, FIELD_A and FIELD_B. Both are all-zero on reset.
- Reset: async clear of both fields. o_next_cell_state=0, o_next_nbrs=0, o_disp_state=0.
- Read: every posedge, o_next_cell_state <= R[rd_y][rd_x], where R is the field selected by i_cur_read_field. Latency is 1 cycle. There is no enable; outputs update every cycle.
- Neighbour bit order, with dx/dy relative to the requested cell:
  - b0 = (-1,-1), b1 = (0,-1), b2 = (+1,-1)
  - b3 = (-1,0), b4 = (+1,0)
  - b5 = (-1,+1), b6 = (0,+1), b7 = (+1,+1)
- Edge handling: neighbours beyond the field edges follow the Optional Feature.
- Write: at posedge with i_wr_en=1, W[wr_y][wr_x] <= i_wr_state, where W = ~i_cur_read_field. The read field is never modified by this port.
- Edit: at posedge with i_edit_en=1 and i_is_simulating=0, R[edit_y][edit_x] <= ~R[edit_y][edit_x]. Edit is ignored while simulating. A held i_edit_en toggles every cycle; the edit source must pulse it.
- Display: every posedge, o_disp_state <= R[disp_y][disp_x]. Latency is 1 cycle.
- Read-during-edit of the same cell: read and display return the pre-edit value. The new value is visible on the next read.
- Read and write in the same cycle never conflict, because they address different fields.
- Out-of-range addresses (x >= FIELD_W or y >= FIELD_H): reads return 0 for the state, all nbrs, and display; writes and edits are dropped.
- Priority: i_clear clears both fields and takes precedence over write and edit in the same cycle. Read outputs in that cycle still reflect pre-clear contents.
- Field swap: a change of i_cur_read_field takes effect on the next read edge. No internal state tracks the swap.

Optional Feature:
- Macro: FIELD_STORE_TORUS_EN.
- Defined: toroidal field. x-1 at x=0 wraps to FIELD_W-1, x+1 at FIELD_W-1 wraps to 0; y wraps the same way.
- Undefined: bounded field. Out-of-field neighbours read as 0.

Test Plan:
- Reset, then read (0,0) and (4,2) of the empty field (5x3) -> o_next_cell_state=0, o_next_nbrs=8'h00, o_disp_state=0.
- Read field A, not simulating: edit-pulse (1,1), then read (1,1), (0,0) and (2,2) ->
  - (1,1): state=1, nbrs=8'h00
  - (0,0): nbrs=8'h80 (b7)
  - (2,2): nbrs=8'h01 (b0)
  - all values appear 1 cycle after the address is applied.
- Read field A: cell (0,1) set; read (4,1) ->
  - TORUS_EN defined: nbrs=8'h10 (b4)
  - TORUS_EN undefined: nbrs=8'h00
- Write loop: i_wr_en=1 with i_wr_state=1 at all 15 cells, read field A -> reads from A are unchanged. Then flip i_cur_read_field to B -> every read returns state=1 with all in-range nbrs set (interior (2,1): 8'hFF).
- i_is_simulating=1 with edit-pulse at (2,1) -> no change. Drop i_is_simulating, pulse again -> (2,1) reads 1.
- Clear with simultaneous write to (3,2) and edit at (3,2) -> both fields all-zero afterwards. Assert rst_n=0 mid-scan -> outputs 0 immediately (async), fields zero.
